// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, mid-bit sampling, one-cycle rx_dv per byte.
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst_n      - synchronous active-low reset
//   rx_serial  - asynchronous serial line, idle high
//   rx_dv      - one-cycle pulse when rx_byte has been loaded with a new byte
//   rx_byte    - last valid received byte, held between frames
//   frame_err  - one-cycle pulse on a low stop bit (only with UART_RX_FRAME_ERR_EN)
// Optional feature macro: UART_RX_FRAME_ERR_EN enables frame_err and stop-bit rejection;
// without it a low stop bit is accepted like a high one.
module uart_rx #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
    // Half-bit offset so every later sample lands in the middle of a bit.
    localparam logic [CW-1:0] HALF = CW'((CLK_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n, byte_n;
    logic          rx_m, rx_s, dv_n;
`ifdef UART_RX_FRAME_ERR_EN
    logic          ferr_n;
`endif

    // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_serial;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            rx_byte <= '0;
            rx_dv   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            rx_byte <= byte_n;
            rx_dv   <= dv_n;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= ferr_n;
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        byte_n  = rx_byte;
        dv_n    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_n  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    // A line that is high again at mid start bit was only a glitch.
                    state_n = rx_s ? IDLE : DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    state_n = CLEANUP;
                    cnt_n   = '0;
`ifdef UART_RX_FRAME_ERR_EN
                    if (rx_s) begin
                        byte_n = shift;
                        dv_n   = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
`else
                    byte_n = shift;
                    dv_n   = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CLEANUP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized checks of uart_rx against a frame-level model.
module tb_uart_rx;
    localparam int CPB = 100;
    localparam int H   = (CPB - 1) / 2;
    localparam int LAT = 2 + (H + 1) + 8 * CPB + CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rx_dv;
    logic [7:0] rx_byte;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         gap;
        int         exp_dv;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    int         ecount = 0;
    int         ferr_n = 0;
    int         dup = 0;
    int         unstable = 0;
    ev_t        dv_q[$];
    logic [7:0] exp_q[$];

    initial forever begin
        @(posedge clk);
        ecount++;
    end

    // Passive monitor: records every rx_dv pulse and watches pulse width / byte stability.
    initial begin
        logic       dv_prev = 1'b0;
        logic       fe_prev = 1'b0;
        logic [7:0] byte_prev = 8'h00;
        forever begin
            @(negedge clk);
            if (rx_dv) dv_q.push_back('{rx_byte, ecount});
            if (rx_dv && dv_prev) dup++;
            if (!rx_dv && rst_n && rx_byte !== byte_prev) unstable++;
`ifdef UART_RX_FRAME_ERR_EN
            if (frame_err) ferr_n++;
            if (frame_err && fe_prev) dup++;
            fe_prev = frame_err;
`endif
            dv_prev   = rx_dv;
            byte_prev = rx_byte;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_serial = bits[i];
            tick(CPB);
        end
        rx_serial = 1'b1;
    endtask

    initial begin
        vec_t       vt[5];
        logic [7:0] last;
        int         st;
        vt[0] = '{8'h69, 1'b1, 0, 1, 8'h69, 0};
        vt[1] = '{8'h00, 1'b1, 0, 1, 8'h00, 0};
        vt[2] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
        vt[3] = '{8'hA5, 1'b1, CPB, 1, 8'hA5, 0};
        vt[4] = FE ? '{8'h55, 1'b0, CPB, 0, 8'hA5, 1} : '{8'h55, 1'b0, CPB, 1, 8'h55, 0};

        tick(3);
        chk("reset_rx_dv", rx_dv, 0);
        chk("reset_rx_byte", rx_byte, 8'h00);
`ifdef UART_RX_FRAME_ERR_EN
        chk("reset_frame_err", frame_err, 0);
`endif
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 5; i++) begin
            dv_q.delete();
            ferr_n = 0;
            st = ecount;
            send(vt[i].data, vt[i].stop);
            tick(vt[i].gap);
            chk($sformatf("vec%0d_dv_count", i), dv_q.size(), vt[i].exp_dv);
            chk($sformatf("vec%0d_rx_byte", i), rx_byte, vt[i].exp_byte);
            if (dv_q.size() > 0) chk($sformatf("vec%0d_latency", i), dv_q[0].cyc - st - 1, LAT);
`ifdef UART_RX_FRAME_ERR_EN
            chk($sformatf("vec%0d_frame_err", i), ferr_n, vt[i].exp_ferr);
`endif
        end

        // 30-cycle glitch must be rejected as a false start, then a real frame follows.
        dv_q.delete();
        rx_serial = 1'b0;
        tick(30);
        rx_serial = 1'b1;
        tick(2 * CPB);
        chk("glitch_no_dv", dv_q.size(), 0);
        send(8'h3C, 1'b1);
        tick(CPB);
        chk("glitch_next_count", dv_q.size(), 1);
        chk("glitch_next_byte", rx_byte, 8'h3C);

        // Reset during data bit 4 of 0xC3 aborts the frame and clears outputs.
        dv_q.delete();
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_serial = ((8'hC3 >> i) & 1) != 0;
            tick(CPB);
        end
        rx_serial = 1'b0;
        tick(CPB / 2);
        rx_serial = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk("midreset_rx_dv", rx_dv, 0);
        chk("midreset_rx_byte", rx_byte, 8'h00);
        rst_n = 1'b1;
        tick(2 * CPB);
        chk("midreset_no_dv", dv_q.size(), 0);
        send(8'h81, 1'b1);
        tick(CPB);
        chk("midreset_next_count", dv_q.size(), 1);
        chk("midreset_next_byte", rx_byte, 8'h81);

        // Random frames against the frame-level model.
        dv_q.delete();
        exp_q.delete();
        ferr_n = 0;
        st = 0;
        last = rx_byte;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            bit         s;
            d = 8'($urandom);
            s = $urandom_range(0, 4) != 0;
            if (s || !FE) begin
                exp_q.push_back(d);
                last = d;
            end else begin
                st++;
            end
            send(d, s);
            tick(s ? $urandom_range(0, 2 * CPB) : CPB + $urandom_range(0, CPB));
        end
        tick(2 * CPB);
        chk("rand_count", dv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dv_q.size(); i++)
            chk($sformatf("rand_byte%0d", i), dv_q[i].b, exp_q[i]);
        chk("rand_final_byte", rx_byte, last);
`ifdef UART_RX_FRAME_ERR_EN
        chk("rand_frame_err", ferr_n, st);
`endif
        chk("pulse_width", dup, 0);
        chk("byte_stable", unstable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: The module SHALL have parameter CLK_PER_BIT, default 100, giving clock cycles per serial bit (legal range 4..65535).
- REQ-002: The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-003: The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-004: The module SHALL have port rx_serial, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
- REQ-005: The module SHALL have port rx_dv, output, 1 bit: one-cycle pulse marking a valid received byte.
- REQ-006: The module SHALL have port rx_byte, output, 8 bits: last valid received byte.
- REQ-007: The module SHALL have port frame_err, output, 1 bit, present only with UART_RX_FRAME_ERR_EN: one-cycle pulse on a bad stop bit.

Function
- REQ-008: rx_serial SHALL pass through a 2-flop synchronizer, reset to 1; all decisions SHALL use the synchronized bit (rx_s).
- REQ-009: The FSM SHALL have exactly the states IDLE, START, DATA, STOP and CLEANUP; the cycle counter SHALL be wide enough for CLK_PER_BIT-1; the bit index SHALL be 3 bits.
- REQ-010: In IDLE with rx_s==0, the FSM SHALL go to START with counter=0.
- REQ-011: In START, the counter SHALL increment until it equals H=(CLK_PER_BIT-1)/2 (integer division); at that point:
  - rx_s==0: go to DATA, counter=0, index=0;
  - rx_s==1: false start, return to IDLE with no output activity.
- REQ-012: In DATA, when counter==CLK_PER_BIT-1, the module SHALL sample rx_s into shift-register bit [index] and reset counter to 0; after index 7 the FSM SHALL go to STOP, otherwise index SHALL increment.
- REQ-013: In STOP, when counter==CLK_PER_BIT-1, the module SHALL sample rx_s as the stop bit and go to CLEANUP; on that same edge:
  - stop==1: rx_byte SHALL load the shift register and rx_dv SHALL go to 1;
  - stop==0, macro defined: rx_dv SHALL stay 0, frame_err SHALL go to 1, rx_byte SHALL be unchanged;
  - stop==0, macro undefined: treated as stop==1.
- REQ-014: CLEANUP SHALL last exactly one cycle, clear rx_dv and frame_err, and return to IDLE; rx_dv and frame_err SHALL each be high for exactly one cycle per frame.
- REQ-015: Latency from the first clk edge sampling rx_serial==0 to the edge setting rx_dv SHALL be 2+(H+1)+8*CLK_PER_BIT+CLK_PER_BIT cycles (= 952 for CLK_PER_BIT=100).
- REQ-016: rx_byte SHALL hold its value between valid frames and SHALL never change while rx_dv==0, except at reset.
- REQ-017: A start edge arriving during CLEANUP SHALL be detected from IDLE on the next cycle, so back-to-back frames with zero idle time SHALL all be received.
- REQ-018: rx_s activity in DATA/STOP outside the sample point SHALL be ignored.

Reset
- REQ-019: With rst_n==0 at a clk edge, the module SHALL set:
  - FSM=IDLE, counter=0, index=0, shift register=0x00;
  - rx_byte=0x00, rx_dv=0, frame_err=0, synchronizer flops=1.
- REQ-020: Reset asserted mid-frame SHALL abort the frame with no rx_dv; reception SHALL restart only on a fresh falling edge after rst_n returns high.

Configuration
- REQ-021: With macro UART_RX_FRAME_ERR_EN defined, port frame_err and the stop-bit rejection of REQ-013 SHALL exist.
- REQ-022: With UART_RX_FRAME_ERR_EN undefined, no frame_err port SHALL exist and every completed frame SHALL produce rx_dv.

Verification (CLK_PER_BIT=100, 10 ns clock, stimulus from a bit-accurate serial driver)
- REQ-023: Frame 0x69 with valid stop -> rx_dv one-cycle pulse 952 cycles after start edge, rx_byte=0x69, frame_err=0.
- REQ-024: Back-to-back frames 0x00, 0xFF, 0xA5 with zero idle -> three rx_dv pulses with rx_byte 0x00, 0xFF, 0xA5 in order.
- REQ-025: 30-cycle low glitch on idle line -> no rx_dv, FSM back in IDLE; following frame 0x3C received correctly.
- REQ-026: Frame 0x55 with stop bit 0, macro defined -> frame_err pulse, rx_dv=0, rx_byte unchanged; macro undefined -> rx_dv pulse with rx_byte=0x55.
- REQ-027: rst_n low for 3 cycles during data bit 4 of 0xC3 -> no rx_dv, outputs at reset values; next frame 0x81 -> rx_byte=0x81.
